// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared memory-interface constants and responder state encoding
package mem_if_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_LINE_W = 128;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port line array, synchronous write and synchronous read
module line_ram
  import mem_if_pkg::*;
#(
  parameter int LINE_W     = MEM_LINE_W,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [LINE_W-1:0] rdata_q;

  // The array has no reset so its contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line memory responder answering each request after a fixed latency
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int LINE_W     = MEM_LINE_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
);

  mem_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  proto_err_q, proto_err_d;
  logic                  commit;
  logic                  unused_addr_bits;

  // Upper line-address bits alias onto the same entries.
  assign unused_addr_bits = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    proto_err_d = proto_err_q;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          addr_d      = mem_addr[DEPTH_LOG2-1:0];
          wdata_d     = mem_wdata;
          wr_d        = mem_write;
          cnt_d       = 4'(LATENCY - 1);
          proto_err_d = proto_err_q | (mem_read & mem_write);
          // A one-cycle latency commits on the capture edge itself.
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      proto_err_q <= proto_err_d;
    end
  end

  line_ram #(
    .LINE_W     (LINE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_line_ram (
    .clk   (clk),
    .rst   (proc_reset),
    .we    (commit & wr_d),
    .re    (commit & ~wr_d),
    .idx   (addr_d),
    .wdata (wdata_d),
    .rdata (mem_rdata)
  );

  assign mem_ready = (state_q == RESP);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

  localparam int LAT_A = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_read, a_write, a_ready, a_perr;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic         b_read, b_write, b_ready, b_perr;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;

  int errors = 0;
  int checks = 0;
  int a_pulses = 0;

  logic [127:0] ref_mem [16];
  bit           ref_valid [16];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(4), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .proc_reset(rst), .mem_read(a_read), .mem_write(a_write),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
    .mem_ready(a_ready), .proto_err(a_perr)
  );

  mem_responder #(.ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(10), .LATENCY(1)) dut_b (
    .clk(clk), .proc_reset(rst), .mem_read(b_read), .mem_write(b_write),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_ready(b_ready), .proto_err(b_perr)
  );

  always @(negedge clk) if (a_ready === 1'b1) a_pulses++;

  // Starts just after a rising edge; returns one cycle after the pulse, in IDLE.
  task automatic a_txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data, output int lat, output logic [127:0] rdata);
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = data;
    lat = -1; rdata = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_ready === 1'b1) begin
        lat = k; rdata = a_rdata;
        break;
      end
    end
    a_read = 1'b0; a_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    checks++; if (a_rdata !== 128'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", a_perr); end
    checks++; if (b_ready !== 1'b0 || b_perr !== 1'b0) begin errors++; $display("FAIL reset_b: got ready=%b perr=%b expected 0 0", b_ready, b_perr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat;
    logic [127:0] rd;
    logic [127:0] d = 128'h11112222_33334444_55556666_77778888;
    a_txn(1'b0, 1'b1, 28'h0000005, d, lat, rd);
    ref_mem[5] = d; ref_valid[5] = 1'b1;
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT_A); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL wr_single_pulse: got %b expected 0", a_ready); end
    a_txn(1'b1, 1'b0, 28'h0000005, '0, lat, rd);
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT_A); end
    checks++; if (rd !== d) begin errors++; $display("FAIL rd_data: got %h expected %h", rd, d); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_rdata !== d) begin errors++; $display("FAIL rd_hold: got %h expected %h", a_rdata, d); end
  endtask

  task automatic test_writeback_allocate();
    int lat1, lat2, p0;
    logic [127:0] rd;
    logic [127:0] pre = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] victim = {$urandom, $urandom, $urandom, $urandom};
    a_txn(1'b0, 1'b1, 28'h0000003, pre, lat1, rd);
    ref_mem[3] = pre; ref_valid[3] = 1'b1;
    p0 = a_pulses;
    a_txn(1'b0, 1'b1, 28'h0000007, victim, lat1, rd);
    ref_mem[7] = victim; ref_valid[7] = 1'b1;
    a_txn(1'b1, 1'b0, 28'h0000013, '0, lat2, rd);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (a_pulses - p0 !== 2) begin errors++; $display("FAIL wb_alloc_pulses: got %0d expected 2", a_pulses - p0); end
    checks++; if (lat1 !== LAT_A || lat2 !== LAT_A) begin errors++; $display("FAIL wb_alloc_latency: got %0d/%0d expected %0d", lat1, lat2, LAT_A); end
    checks++; if (rd !== pre) begin errors++; $display("FAIL wb_alloc_data: got %h expected %h", rd, pre); end
  endtask

  task automatic test_aliasing();
    int lat;
    logic [127:0] rd;
    logic [127:0] a = {$urandom, $urandom, $urandom, $urandom};
    a_txn(1'b0, 1'b1, 28'h0000021, a, lat, rd);
    ref_mem[1] = a; ref_valid[1] = 1'b1;
    a_txn(1'b1, 1'b0, 28'h0000001, '0, lat, rd);
    checks++; if (rd !== a) begin errors++; $display("FAIL alias_data: got %h expected %h", rd, a); end
  endtask

  task automatic test_proto_err();
    int lat;
    logic [127:0] rd;
    logic [127:0] d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL perr_clean: got %b expected 0", a_perr); end
    a_txn(1'b1, 1'b1, 28'h0000002, d, lat, rd);
    ref_mem[2] = d; ref_valid[2] = 1'b1;
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL perr_latency: got %0d expected %0d", lat, LAT_A); end
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", a_perr); end
    a_txn(1'b1, 1'b0, 28'h0000002, '0, lat, rd);
    checks++; if (rd !== d) begin errors++; $display("FAIL perr_as_write: got %h expected %h", rd, d); end
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", a_perr); end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] rd, d;
    logic [3:0] idx;
    logic [23:0] upper;
    bit is_wr;
    for (int i = 0; i < 24; i++) begin
      is_wr = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      upper = 24'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      a_txn(!is_wr, is_wr, {upper, idx}, d, lat, rd);
      checks++; if (lat !== LAT_A) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT_A); end
      if (is_wr) begin
        ref_mem[idx] = d; ref_valid[idx] = 1'b1;
      end else if (ref_valid[idx]) begin
        checks++; if (rd !== ref_mem[idx]) begin errors++; $display("FAIL rand_data[%0d] idx %0d: got %h expected %h", i, idx, rd, ref_mem[idx]); end
      end
    end
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL rand_perr_sticky: got %b expected 1", a_perr); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit seen = 0;
    logic [127:0] rd;
    a_txn(1'b1, 1'b0, 28'h0000005, '0, lat, rd);
    a_read = 1'b1; a_addr = 28'h0000005;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1; a_read = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL midbusy_ready: got %b expected 0", a_ready); end
    checks++; if (a_rdata !== 128'd0) begin errors++; $display("FAIL midbusy_rdata: got %h expected 0", a_rdata); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL midbusy_perr_clear: got %b expected 0", a_perr); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_ready === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midbusy_no_pulse: got pulse expected none"); end
    @(posedge clk); #1;
    a_txn(1'b1, 1'b0, 28'h0000005, '0, lat, rd);
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT_A); end
    checks++; if (rd !== ref_mem[5]) begin errors++; $display("FAIL array_survives_reset: got %h expected %h", rd, ref_mem[5]); end
  endtask

  task automatic test_latency1();
    bit is_wr = 1;
    logic [127:0] last = {$urandom, $urandom, $urandom, $urandom};
    b_addr = 28'($urandom);
    b_wdata = last; b_write = 1'b1; b_read = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (b_ready !== 1'(k % 2)) begin errors++; $display("FAIL lat1_ready[%0d]: got %b expected %b", k, b_ready, 1'(k % 2)); end
      if (b_ready === 1'b1) begin
        if (!is_wr) begin
          checks++; if (b_rdata !== last) begin errors++; $display("FAIL lat1_data[%0d]: got %h expected %h", k, b_rdata, last); end
          last = {$urandom, $urandom, $urandom, $urandom};
          b_addr = 28'($urandom);
        end
        is_wr = !is_wr;
        b_write = is_wr; b_read = !is_wr; b_wdata = last;
      end
    end
    b_write = 1'b0; b_read = 1'b0;
    checks++; if (b_perr !== 1'b0) begin errors++; $display("FAIL lat1_perr: got %b expected 0", b_perr); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    test_reset();
    test_write_read();
    test_writeback_allocate();
    test_aliasing();
    test_proto_err();
    test_random();
    test_reset_mid_busy();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
